// File: rtl/nibble_serial_adder.sv
// Multi-precision adder sequencer: feeds an external 4-bit adder one nibble per cycle,
// registering the carry between nibbles. Optional subtract mode under macro SUB_EN.

// 4-bit ripple-carry adder driven through the sequencer's Add_* ports.
module adder4_ripple (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_fa
            assign sum[i]  = a[i] ^ b[i] ^ c[i];
            assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] Op_A,
    input  logic [WIDTH-1:0] Op_B,
    input  logic             Cin,
`ifdef SUB_EN
    input  logic             Sub,
`endif
    output logic [3:0]       Add_A,
    output logic [3:0]       Add_B,
    output logic             Add_Cin,
    input  logic [3:0]       Add_Sum,
    input  logic             Add_Carry,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry_out
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovld_q, ovld_d;
    logic              invert_b;
    logic              init_carry;
    logic [IDXW+1:0]   nib_sel;
    logic              last_nib;

`ifdef SUB_EN
    logic sub_q, sub_d;

    // Subtract is A + ~B + 1, so the initial carry is forced high and Cin ignored.
    assign invert_b   = sub_q;
    assign init_carry = Sub ? 1'b1 : Cin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sub_q <= 1'b0;
        else        sub_q <= sub_d;
    end
`else
    assign invert_b   = 1'b0;
    assign init_carry = Cin;
`endif

    assign nib_sel  = {idx_q, 2'b00};
    assign last_nib = (idx_q == IDXW'(NIBBLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovld_q  <= ovld_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovld_d   = ovld_q;
`ifdef SUB_EN
        sub_d    = sub_q;
`endif
        In_ready = 1'b0;
        Add_A    = 4'h0;
        Add_B    = 4'h0;
        Add_Cin  = 1'b0;

        case (state_q)
            S_IDLE: begin
                In_ready = 1'b1;
                if (In_valid) begin
                    a_d     = Op_A;
                    b_d     = Op_B;
                    carry_d = init_carry;
                    idx_d   = '0;
                    sum_d   = '0;
`ifdef SUB_EN
                    sub_d   = Sub;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                Add_A   = a_q[nib_sel +: 4];
                Add_B   = b_q[nib_sel +: 4] ^ {4{invert_b}};
                Add_Cin = carry_q;
                sum_d[nib_sel +: 4] = Add_Sum;
                carry_d = Add_Carry;
                if (last_nib) begin
                    // Index parks at 0 so the part-select never points past the operand.
                    idx_d   = '0;
                    cout_d  = Add_Carry;
                    ovld_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                if (Out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Out_valid = ovld_q;
    assign Sum       = sum_q;
    assign Carry_out = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector and random bench for nibble_serial_adder (WIDTH=16) driving the real 4-bit adder.
module tb_nibble_serial_adder;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          In_valid = 1'b0;
    logic          In_ready;
    logic [W-1:0]  Op_A = '0;
    logic [W-1:0]  Op_B = '0;
    logic          Cin = 1'b0;
`ifdef SUB_EN
    logic          Sub = 1'b0;
`endif
    logic [3:0]    Add_A, Add_B, Add_Sum;
    logic          Add_Cin, Add_Carry;
    logic          Out_valid;
    logic          Out_ready = 1'b0;
    logic [W-1:0]  Sum;
    logic          Carry_out;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .In_valid(In_valid), .In_ready(In_ready),
        .Op_A(Op_A), .Op_B(Op_B), .Cin(Cin),
`ifdef SUB_EN
        .Sub(Sub),
`endif
        .Add_A(Add_A), .Add_B(Add_B), .Add_Cin(Add_Cin),
        .Add_Sum(Add_Sum), .Add_Carry(Add_Carry),
        .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Sum(Sum), .Carry_out(Carry_out)
    );

    adder4_ripple u_add4 (
        .a(Add_A), .b(Add_B), .cin(Add_Cin), .sum(Add_Sum), .cout(Add_Carry)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
    endtask

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        Op_A = a;
        Op_B = b;
        Cin  = cin;
`ifdef SUB_EN
        Sub  = sub;
`else
        if (sub) chk("drive", "sub_unsupported", 32'(sub), 32'd0);
`endif
    endtask

    // Waits for Out_valid after an accept edge; returns the number of edges taken.
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!Out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic take_result(input string tag);
        @(negedge clk); Out_ready = 1'b1;
        @(posedge clk); #1; Out_ready = 1'b0;
        chk(tag, "out_valid_drop", 32'(Out_valid), 32'd0);
        chk(tag, "in_ready_back", 32'(In_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input vec_t v);
        int cyc;
        @(negedge clk);
        drive_op(v.a, v.b, v.cin, v.sub);
        In_valid = 1'b1;
        chk(tag, "in_ready", 32'(In_ready), 32'd1);
        @(posedge clk); #1; In_valid = 1'b0;
        wait_result(cyc);
        chk(tag, "latency", 32'(cyc), 32'd4);
        chk(tag, "sum", 32'(Sum), 32'(v.s));
        chk(tag, "carry_out", 32'(Carry_out), 32'(v.c));
        take_result(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int bad;
        vec_t v;

        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
        vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
        vecs.push_back('{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0});
`ifdef SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
        vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
        vecs.push_back('{16'h0010, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b1});
        vecs.push_back('{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0});
`endif

        // Reset state
        #2;
        chk("reset", "out_valid", 32'(Out_valid), 32'd0);
        chk("reset", "sum", 32'(Sum), 32'd0);
        chk("reset", "carry_out", 32'(Carry_out), 32'd0);
        chk("reset", "add_a", 32'({Add_A, Add_B, Add_Cin}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("reset", "in_ready", 32'(In_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("vec%0d", i), vecs[i]);

        // Backpressure, ignored In_valid during RUN/DONE, and the one-cycle bubble after take
        @(negedge clk);
        drive_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        In_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp", "run_add_a", 32'(Add_A), 32'h4);
        chk("bp", "run_add_b", 32'(Add_B), 32'h1);
        chk("bp", "run_add_cin", 32'(Add_Cin), 32'd0);
        chk("bp", "run_in_ready", 32'(In_ready), 32'd0);
        drive_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        wait_result(cyc);
        chk("bp", "latency", 32'(cyc), 32'd4);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp", "held_sum", 32'(Sum), 32'h5555);
            chk("bp", "held_state", 32'({Carry_out, Out_valid, In_ready}), 32'b010);
        end
        @(negedge clk); Out_ready = 1'b1;
        @(posedge clk); #1; Out_ready = 1'b0;
        chk("bp", "taken_out_valid", 32'(Out_valid), 32'd0);
        chk("bp", "bubble_in_ready", 32'(In_ready), 32'd1);
        @(posedge clk); #1; In_valid = 1'b0;
        chk("bp", "second_add_a", 32'({Add_A, Add_B, Add_Cin}), 32'h1FF);
        wait_result(cyc);
        chk("bp", "second_latency", 32'(cyc), 32'd4);
        chk("bp", "second_sum", 32'({Carry_out, Sum}), 32'h1FFFF);
        take_result("bp");

        // Reset while RUN is at nibble 2
        @(negedge clk);
        drive_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        In_valid = 1'b1;
        @(posedge clk); #1; In_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("midrst", "pre_add_a", 32'(Add_A), 32'hF);
        chk("midrst", "pre_add_cin", 32'(Add_Cin), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst", "add_ports", 32'({Add_A, Add_B, Add_Cin}), 32'd0);
        chk("midrst", "outputs", 32'({Out_valid, Carry_out, Sum}), 32'd0);
        chk("midrst", "in_ready", 32'(In_ready), 32'd1);
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (Out_valid) bad++;
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (Out_valid) bad++;
        end
        chk("midrst", "no_out_valid", 32'(bad), 32'd0);
        run_op("midrst_next", '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0});

        // Random ops back to back with Out_ready toggled randomly
        for (int n = 0; n < 1000; n++) begin
            logic [W:0] exp_r;
            logic       got, done;
            int         wait_cyc;
            v.a   = W'($urandom);
            v.b   = W'($urandom);
            v.cin = 1'($urandom_range(0, 1));
`ifdef SUB_EN
            v.sub = 1'($urandom_range(0, 1));
`else
            v.sub = 1'b0;
`endif
            exp_r = v.sub ? ({1'b0, v.a} + {1'b0, ~v.b} + 17'd1)
                          : ({1'b0, v.a} + {1'b0, v.b} + {16'd0, v.cin});
            @(negedge clk);
            drive_op(v.a, v.b, v.cin, v.sub);
            In_valid = 1'b1;
            @(posedge clk); #1; In_valid = 1'b0;
            got = 1'b0;
            done = 1'b0;
            wait_cyc = 0;
            while (!done && wait_cyc < 60) begin
                @(negedge clk);
                Out_ready = 1'($urandom_range(0, 1));
                if (Out_valid && !got) begin
                    got = 1'b1;
                    chk($sformatf("rand%0d", n), "result", 32'({Carry_out, Sum}), 32'(exp_r));
                end
                if (Out_valid && Out_ready) done = 1'b1;
                @(posedge clk);
                wait_cyc++;
            end
            #1; Out_ready = 1'b0;
            chk($sformatf("rand%0d", n), "completed", 32'(done), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
